// File: rtl/bht_predictor_pkg.sv
// Shared CPU package for the branch history table.
// Mode encodings, index width and counter reset helpers.
package bht_predictor_pkg;

  typedef enum logic {
    BIMODAL = 1'b0,
    GSHARE  = 1'b1
  } mode_e;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Weakly-not-taken: 2^(w-1)-1, which is 0 for w=1.
  function automatic int wnt_val(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Bundle of the ID lookup and EX resolve signals.
// master drives lookups/updates; slave is the predictor.
interface bht_predictor_if #(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4
);
  logic              id_branch;
  logic [31:0]       id_pc;
  logic              pred;
  logic [IDX_W-1:0]  pred_idx;
  logic              ex_branch;
  logic [IDX_W-1:0]  ex_idx;
  logic              ex_pred;
  logic              ex_taken;
  logic              fail;
  logic              flush;
  logic [HIST_W-1:0] ghr;
  logic [15:0]       br_cnt;
  logic [15:0]       miss_cnt;

  modport master (
    output id_branch, id_pc,
    output ex_branch, ex_idx,
    output ex_pred, ex_taken,
    input  pred, pred_idx,
    input  fail, flush, ghr,
    input  br_cnt, miss_cnt
  );

  modport slave (
    input  id_branch, id_pc,
    input  ex_branch, ex_idx,
    input  ex_pred, ex_taken,
    output pred, pred_idx,
    output fail, flush, ghr,
    output br_cnt, miss_cnt
  );
endinterface

// File: rtl/bht_predictor_sat_counter.sv
// Saturating up/down counter, one table entry.
// en_i gates, inc_i selects up (1) or down (0).
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] val_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;
  logic         up_ok;
  logic         dn_ok;

  assign up_ok = en_i && inc_i && (val_q != '1);
  assign dn_ok = en_i && !inc_i && (val_q != '0);

  always_comb begin
    val_d = val_q;
    unique case (1'b1)
      up_ok:   val_d = val_q + 1'b1;
      dn_ok:   val_d = val_q - 1'b1;
      default: val_d = val_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) val_q <= RST_VAL;
    else        val_q <= val_d;
  end

  assign val_o = val_q;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: bimodal or gshare lookup in ID,
// counter/history update and mispredict stats from EX.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int CTR_W   = 2,
  parameter  int HIST_W  = 4,
  parameter  int MODE    = 0,
  localparam int IDX_W   = idx_w(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_branch_i,
  input  logic [31:0]       id_pc_i,
  output logic              pred_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              ex_branch_i,
  input  logic [IDX_W-1:0]  ex_idx_i,
  input  logic              ex_pred_i,
  input  logic              ex_taken_i,
  output logic              fail_o,
  output logic              flush_o,
  output logic [HIST_W-1:0] ghr_o,
  output logic [15:0]       br_cnt_o,
  output logic [15:0]       miss_cnt_o
);

  localparam bit GS = (MODE == int'(GSHARE));
  localparam logic [CTR_W-1:0] RST_CTR =
    CTR_W'(wnt_val(CTR_W));

  logic [CTR_W-1:0]  ctr [ENTRIES];
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  lkp_idx;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [15:0]       br_q, br_d;
  logic [15:0]       miss_q, miss_d;
  logic              unused_pc;

  assign unused_pc = ^{id_pc_i[31:IDX_W+2],
                       id_pc_i[1:0]};

  assign pc_idx  = id_pc_i[IDX_W+1:2];
  assign lkp_idx = GS ? (pc_idx ^ IDX_W'(ghr_q))
                      : pc_idx;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    sat_counter #(
      .W       (CTR_W),
      .RST_VAL (RST_CTR)
    ) u_ctr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (ex_branch_i &&
              (ex_idx_i == IDX_W'(g))),
      .inc_i (ex_taken_i),
      .val_o (ctr[g])
    );
  end

  // Lookup sees the pre-edge table; no update bypass.
  assign pred_o     = id_branch_i &&
                      ctr[lkp_idx][CTR_W-1];
  assign pred_idx_o = lkp_idx;
  assign fail_o     = ex_branch_i &&
                      (ex_pred_i ^ ex_taken_i);
  assign flush_o    = fail_o || pred_o;

  always_comb begin
    ghr_d  = ghr_q;
    br_d   = br_q;
    miss_d = miss_q;
    if (ex_branch_i) begin
      ghr_d = HIST_W'({ghr_q, ex_taken_i});
      if (br_q != '1) br_d = br_q + 16'd1;
    end
    if (fail_o && miss_q != '1)
      miss_d = miss_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_q  <= '0;
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      br_q   <= br_d;
      miss_q <= miss_d;
    end
  end

  assign ghr_o      = ghr_q;
  assign br_cnt_o   = br_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench: bimodal and gshare instances,
// training, collision, mispredict, saturation, reset.
module tb_bht_predictor;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  bht_predictor_if #(.IDX_W(4), .HIST_W(4)) bif ();
  bht_predictor_if #(.IDX_W(4), .HIST_W(4)) gif ();

  bht_predictor u_bim (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .id_branch_i (bif.id_branch),
    .id_pc_i     (bif.id_pc),
    .pred_o      (bif.pred),
    .pred_idx_o  (bif.pred_idx),
    .ex_branch_i (bif.ex_branch),
    .ex_idx_i    (bif.ex_idx),
    .ex_pred_i   (bif.ex_pred),
    .ex_taken_i  (bif.ex_taken),
    .fail_o      (bif.fail),
    .flush_o     (bif.flush),
    .ghr_o       (bif.ghr),
    .br_cnt_o    (bif.br_cnt),
    .miss_cnt_o  (bif.miss_cnt)
  );

  bht_predictor #(.MODE(1)) u_gs (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .id_branch_i (gif.id_branch),
    .id_pc_i     (gif.id_pc),
    .pred_o      (gif.pred),
    .pred_idx_o  (gif.pred_idx),
    .ex_branch_i (gif.ex_branch),
    .ex_idx_i    (gif.ex_idx),
    .ex_pred_i   (gif.ex_pred),
    .ex_taken_i  (gif.ex_taken),
    .fail_o      (gif.fail),
    .flush_o     (gif.flush),
    .ghr_o       (gif.ghr),
    .br_cnt_o    (gif.br_cnt),
    .miss_cnt_o  (gif.miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_b(input logic br,
                      input logic [3:0] idx,
                      input logic p,
                      input logic t);
    bif.ex_branch = br;
    bif.ex_idx    = idx;
    bif.ex_pred   = p;
    bif.ex_taken  = t;
  endtask

  task automatic ex_g(input logic br,
                      input logic [3:0] idx,
                      input logic p,
                      input logic t);
    gif.ex_branch = br;
    gif.ex_idx    = idx;
    gif.ex_pred   = p;
    gif.ex_taken  = t;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bif.id_branch = 1'b1;
    bif.id_pc     = 32'h10;
    gif.id_branch = 1'b1;
    gif.id_pc     = 32'h10;
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    ex_g(1'b0, 4'd0, 1'b0, 1'b0);

    // in reset
    #3;
    check("rst_pred", 32'(bif.pred), 32'd0);
    check("rst_br", 32'(bif.br_cnt), 32'd0);
    check("rst_ghr", 32'(bif.ghr), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    check("lk_pred", 32'(bif.pred), 32'd0);
    check("lk_idx", 32'(bif.pred_idx), 32'd4);
    check("lk_flush", 32'(bif.flush), 32'd0);

    // mispredict on idx 5
    bif.id_branch = 1'b0;
    ex_b(1'b1, 4'd5, 1'b0, 1'b1);
    #1;
    check("mp_fail", 32'(bif.fail), 32'd1);
    check("mp_flush", 32'(bif.flush), 32'd1);
    tick();
    check("mp_miss", 32'(bif.miss_cnt), 32'd1);
    check("mp_br", 32'(bif.br_cnt), 32'd1);

    // train idx 4: 1 -> 3
    ex_b(1'b1, 4'd4, 1'b1, 1'b1);
    tick();
    tick();
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    bif.id_branch = 1'b1;
    bif.id_pc     = 32'h10;
    #1;
    check("tr_pred", 32'(bif.pred), 32'd1);
    check("tr_flush", 32'(bif.flush), 32'd1);

    // untrain: 3 -> 0, fourth saturates
    ex_b(1'b1, 4'd4, 1'b0, 1'b0);
    repeat (4) tick();
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("un_pred", 32'(bif.pred), 32'd0);
    check("un_ghr", 32'(bif.ghr), 32'd0);

    // one taken: 0 -> 1, still not taken
    ex_b(1'b1, 4'd4, 1'b1, 1'b1);
    tick();
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("sat0_pred", 32'(bif.pred), 32'd0);

    // collision: update and lookup idx 4
    ex_b(1'b1, 4'd4, 1'b1, 1'b1);
    #1;
    check("col_pre", 32'(bif.pred), 32'd0);
    tick();
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("col_post", 32'(bif.pred), 32'd1);
    check("col_ghr", 32'(bif.ghr), 32'd3);

    // idle EX: inputs ignored
    ex_b(1'b0, 4'd4, 1'b0, 1'b1);
    #1;
    check("idle_fail", 32'(bif.fail), 32'd0);
    tick();
    check("idle_br", 32'(bif.br_cnt), 32'd9);
    check("idle_miss", 32'(bif.miss_cnt), 32'd1);
    check("idle_pred", 32'(bif.pred), 32'd1);

    // gshare
    ex_g(1'b1, 4'd0, 1'b1, 1'b1);
    repeat (3) tick();
    ex_g(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("gs_ghr", 32'(gif.ghr), 32'd7);
    check("gs_idx", 32'(gif.pred_idx), 32'd3);
    check("gs_pred", 32'(gif.pred), 32'd0);
    check("gs_br", 32'(gif.br_cnt), 32'd3);

    // stat saturation
    ex_b(1'b1, 4'd9, 1'b0, 1'b1);
    repeat (65536) @(posedge clk);
    #1;
    check("sat_miss", 32'(bif.miss_cnt), 32'hFFFF);
    check("sat_br", 32'(bif.br_cnt), 32'hFFFF);

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("ar_miss", 32'(bif.miss_cnt), 32'd0);
    check("ar_br", 32'(bif.br_cnt), 32'd0);
    check("ar_ghr", 32'(bif.ghr), 32'd0);
    check("ar_pred", 32'(bif.pred), 32'd0);
    check("ar_gghr", 32'(gif.ghr), 32'd0);

    // first update after release hits reset value
    ex_b(1'b1, 4'd4, 1'b1, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    ex_b(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("rel_pred", 32'(bif.pred), 32'd1);
    check("rel_br", 32'(bif.br_cnt), 32'd1);
    check("rel_miss", 32'(bif.miss_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of table entries (power of two, 4..256).
REQ-002 SHALL have parameter CTR_W, default 2, meaning the saturating counter width (1..4).
REQ-003 SHALL have parameter HIST_W, default 4, meaning the global history width (1..log2(ENTRIES)).
REQ-004 SHALL have parameter MODE, default 0, meaning the index mode (0 = bimodal, 1 = gshare).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port id_branch_i, input, 1 bit: a conditional branch is in ID this cycle.
REQ-008 SHALL have port id_pc_i, input, 32 bits: PC of the ID-stage instruction.
REQ-009 SHALL have port pred_o, output, 1 bit: predict taken for the ID branch.
REQ-010 SHALL have port pred_idx_o, output, IDX_W = log2(ENTRIES) bits: table index used for the lookup; the pipeline carries it to EX.
REQ-011 SHALL have port ex_branch_i, input, 1 bit: a branch is resolving in EX this cycle.
REQ-012 SHALL have port ex_idx_i, input, IDX_W bits: the carried lookup index.
REQ-013 SHALL have port ex_pred_i, input, 1 bit: the carried prediction.
REQ-014 SHALL have port ex_taken_i, input, 1 bit: the actual outcome (ALU zero result for beq).
REQ-015 SHALL have port fail_o, output, 1 bit: mispredict; the PC selects the recovery target.
REQ-016 SHALL have port flush_o, output, 1 bit: flush the IF/ID register.
REQ-017 SHALL have port ghr_o, output, HIST_W bits: the global history register.
REQ-018 SHALL have port br_cnt_o, output, 16 bits: count of resolved branches.
REQ-019 SHALL have port miss_cnt_o, output, 16 bits: count of mispredicts.

Function
REQ-020 SHALL hold ENTRIES counters of CTR_W bits each.
REQ-021 SHALL read the table combinationally, with no clock latency.
REQ-022 SHALL compute the lookup index in bimodal mode as id_pc_i[IDX_W+1:2].
REQ-023 SHALL compute the lookup index in gshare mode as id_pc_i[IDX_W+1:2] XOR ghr_o zero-extended to IDX_W bits.
REQ-024 SHALL drive pred_o = id_branch_i AND MSB of the indexed counter, and SHALL drive pred_idx_o regardless of id_branch_i.
REQ-025 SHALL drive fail_o = ex_branch_i AND (ex_pred_i XOR ex_taken_i), combinationally.
REQ-026 SHALL drive flush_o = fail_o OR pred_o.
REQ-027 SHALL, on a clock edge with ex_branch_i=1 and ex_taken_i=1, increment counter[ex_idx_i], saturating at 2^CTR_W-1.
REQ-028 SHALL, on a clock edge with ex_branch_i=1 and ex_taken_i=0, decrement counter[ex_idx_i], saturating at 0.
REQ-029 SHALL leave the table unchanged when ex_branch_i=0.
REQ-030 SHALL, on a clock edge with ex_branch_i=1, shift ghr_o left and insert ex_taken_i into the LSB; ghr_o SHALL be maintained in both modes.
REQ-031 SHALL, when a lookup and an update hit the same index in one cycle, base the lookup on the pre-update value, with no bypass.
REQ-032 SHALL increment br_cnt_o on every edge with ex_branch_i=1, and SHALL increment miss_cnt_o on every edge with fail_o=1.
REQ-033 SHALL saturate both statistic counters at 16'hFFFF rather than wrapping.
REQ-034 SHALL ignore ex_pred_i and ex_taken_i when ex_branch_i=0.

Reset
REQ-035 SHALL, while rst_i=0, asynchronously set every counter to weakly-not-taken, 2^(CTR_W-1)-1 (CTR_W=1: 0).
REQ-036 SHALL, while rst_i=0, asynchronously clear ghr_o, br_cnt_o and miss_cnt_o to 0.
REQ-037 SHALL keep the combinational outputs valid from the reset state during reset (pred_o=0 for any PC).
REQ-038 SHALL discard any update in progress when reset asserts mid-operation; the first update after release SHALL apply to reset values.

Structure
REQ-039 SHALL take the weakly-not-taken reset value, IDX_W derivation and MODE encodings (BIMODAL=0, GSHARE=1) from the shared CPU package.
REQ-040 SHALL be implemented as one module, with one natural sub-module sat_counter (parametrised width, inc/dec/enable), instantiated ENTRIES times.

Verification
REQ-041 SHALL check reset: default parameters, release reset, id_branch_i=1, id_pc_i=0x10 -> pred_o=0, pred_idx_o=4, flush_o=0.
REQ-042 SHALL check training: two taken updates at idx 4, then lookup at PC 0x10 -> pred_o=1, flush_o=1; four not-taken updates -> counter=0, saturated, pred_o=0.
REQ-043 SHALL check mispredict: ex_branch_i=1, ex_pred_i=0, ex_taken_i=1 -> fail_o=1 same cycle; miss_cnt_o=1 and br_cnt_o=1 after the edge.
REQ-044 SHALL check gshare: MODE=1, three taken updates -> ghr_o=4'b0111; lookup PC 0x10 -> pred_idx_o=4 XOR 7=3.
REQ-045 SHALL check the same-index collision: counter=1, update taken and lookup idx 4 in one cycle -> pred_o=0 that cycle, pred_o=1 the next.
REQ-046 SHALL check saturation and reset: force 65536 mispredicts -> miss_cnt_o holds 0xFFFF; assert rst_i=0 mid-stream -> all counts 0 immediately, without waiting for a clock edge.
